// File: rtl/ex_stage.sv
// RV32I execute stage: ALU result, branch/jump resolution (combinational) plus an EX/MEM capture register.
// Latency: comb outputs 0 cycles, _q outputs 1 cycle; stall=1 holds the _q registers (reset overrides stall).
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall,
    output logic [XLEN-1:0] alu_result,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] alu_result_q,
    output logic            branch_taken_q,
    output logic [XLEN-1:0] branch_target_q
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    logic            is_op;
    logic            alt;
    logic [XLEN-1:0] opb;
    logic [4:0]      shamt;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic            lt_s;
    logic            lt_u;
    logic            br_eq;
    logic            br_lt_s;
    logic            br_lt_u;

    // Second ALU operand is rs2 only for register-register ops; everything else uses the immediate.
    assign is_op       = (opcode == OPC_OP);
    assign alt         = (funct7 == F7_ALT);
    assign opb         = is_op ? rs2_val : imm;
    assign shamt       = opb[4:0];
    assign sum         = rs1_val + opb;
    assign diff        = rs1_val - opb;
    assign lt_s        = $signed(rs1_val) < $signed(opb);
    assign lt_u        = rs1_val < opb;
    assign pc_plus_imm = pc_in + imm;
    assign jalr_sum    = rs1_val + imm;

    assign br_eq   = (rs1_val == rs2_val);
    assign br_lt_s = $signed(rs1_val) < $signed(rs2_val);
    assign br_lt_u = rs1_val < rs2_val;

    always_comb begin
        alu_result = '0;
        case (opcode)
            OPC_OP_IMM, OPC_OP: begin
                if (!(is_op && funct7 == F7_MULDIV)) begin
                    case (funct3)
                        3'b000:  alu_result = (is_op && alt) ? diff : sum;
                        3'b001:  alu_result = rs1_val << shamt;
                        3'b010:  alu_result = {{(XLEN-1){1'b0}}, lt_s};
                        3'b011:  alu_result = {{(XLEN-1){1'b0}}, lt_u};
                        3'b100:  alu_result = rs1_val ^ opb;
                        3'b101:  alu_result = alt ? $unsigned($signed(rs1_val) >>> shamt)
                                                  : rs1_val >> shamt;
                        3'b110:  alu_result = rs1_val | opb;
                        default: alu_result = rs1_val & opb;
                    endcase
                end
            end
            OPC_LOAD, OPC_STORE: alu_result = sum;
            OPC_LUI:             alu_result = imm;
            OPC_AUIPC:           alu_result = pc_plus_imm;
            OPC_JAL, OPC_JALR:   alu_result = pc_in + XLEN'(4);
            default:             alu_result = '0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  branch_taken = br_eq;
                    3'b001:  branch_taken = !br_eq;
                    3'b100:  branch_taken = br_lt_s;
                    3'b101:  branch_taken = !br_lt_s;
                    3'b110:  branch_taken = br_lt_u;
                    3'b111:  branch_taken = !br_lt_u;
                    default: branch_taken = 1'b0;
                endcase
            end
            OPC_JAL, OPC_JALR: branch_taken = 1'b1;
            default:           branch_taken = 1'b0;
        endcase
    end

    assign branch_target = (opcode == OPC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_plus_imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q    <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else if (!stall) begin
            alu_result_q    <= alu_result;
            branch_taken_q  <= branch_taken;
            branch_target_q <= branch_target;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed ALU/branch/jump vectors, randomised OP/OP-IMM against a reference model,
// and register reset/capture/stall behaviour; expectations flow through a scoreboard queue.
module tb_ex_stage;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc_in;
    logic        stall;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] alu_result_q;
    logic        branch_taken_q;
    logic [31:0] branch_target_q;

    ex_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .rs1_val         (rs1_val),
        .rs2_val         (rs2_val),
        .imm             (imm),
        .pc_in           (pc_in),
        .stall           (stall),
        .alu_result      (alu_result),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .alu_result_q    (alu_result_q),
        .branch_taken_q  (branch_taken_q),
        .branch_target_q (branch_target_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] alu, input logic taken,
                            input logic [31:0] tgt);
        exp_t e;
        e.tag = tag; e.alu = alu; e.taken = taken; e.tgt = tgt;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            e.tag = "none"; e.alu = 'x; e.taken = 1'bx; e.tgt = 'x;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] pc);
        opcode = opc; funct3 = f3; funct7 = f7;
        rs1_val = a; rs2_val = b; imm = im; pc_in = pc;
    endtask

    task automatic cmp_comb();
        exp_t e;
        pop_exp(e);
        check({e.tag, ".alu"},   alu_result,            e.alu);
        check({e.tag, ".taken"}, {31'b0, branch_taken}, {31'b0, e.taken});
        check({e.tag, ".tgt"},   branch_target,         e.tgt);
    endtask

    task automatic cmp_reg();
        exp_t e;
        pop_exp(e);
        check({e.tag, ".alu_q"},   alu_result_q,            e.alu);
        check({e.tag, ".taken_q"}, {31'b0, branch_taken_q}, {31'b0, e.taken});
        check({e.tag, ".tgt_q"},   branch_target_q,         e.tgt);
    endtask

    task automatic vec(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pc, input logic [31:0] e_alu,
                       input logic e_taken, input logic [31:0] e_tgt);
        drive(opc, f3, f7, a, b, im, pc);
        push_exp(tag, e_alu, e_taken, e_tgt);
        #1;
        cmp_comb();
    endtask

    // Reference ALU for OP / OP-IMM, written from the ISA description.
    function automatic logic [31:0] model_alu(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] im);
        logic [31:0] y;
        logic [63:0] ext;
        int          sh;
        logic        sign_lt;
        y  = (opc == OP) ? b : im;
        sh = int'(y[4:0]);
        if (opc == OP && f7 == 7'h01) return 32'h0;
        sign_lt = (a[31] != y[31]) ? a[31] : (a < y);
        case (f3)
            3'd0: return (opc == OP && f7 == 7'h20) ? a + (~y + 32'd1) : a + y;
            3'd1: return a << sh;
            3'd2: return {31'b0, sign_lt};
            3'd3: return {31'b0, (a < y)};
            3'd4: return a ^ y;
            3'd5: begin
                if (f7 == 7'h20) begin
                    ext = {{32{a[31]}}, a} >> sh;
                    return ext[31:0];
                end
                return a >> sh;
            end
            3'd6: return a | y;
            default: return a & y;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  r_f7;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_b, r_im, r_pc;
        int          pick;

        rst_n = 1'b0;
        stall = 1'b0;
        drive(OP_IMM, 3'b000, 7'h00, 32'd5, 32'd0, 32'd3, 32'd0);
        #2;
        // Reset is asserted before the first clock edge.
        push_exp("reset", 32'h0, 1'b0, 32'h0);
        cmp_reg();

        vec("addi",  OP_IMM, 3'b000, 7'h00, 32'd5,        32'd0,        32'd3, 32'd0, 32'd8,        1'b0, 32'd3);
        vec("slti",  OP_IMM, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd0,        32'd1, 32'd0, 32'd1,        1'b0, 32'd1);
        vec("srli",  OP_IMM, 3'b101, 7'h00, 32'h80000000, 32'd0,        32'd4, 32'd0, 32'h08000000, 1'b0, 32'd4);
        vec("srai",  OP_IMM, 3'b101, 7'h20, 32'h80000000, 32'd0,        32'd4, 32'd0, 32'hF8000000, 1'b0, 32'd4);
        vec("sub",   OP,     3'b000, 7'h20, 32'd7,        32'd4,        32'd0, 32'd0, 32'd3,        1'b0, 32'd0);
        vec("sltu",  OP,     3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd0, 32'd0,        1'b0, 32'd0);
        vec("or",    OP,     3'b110, 7'h00, 32'h0000FF00, 32'h00FF0000, 32'd0, 32'd0, 32'h00FFFF00, 1'b0, 32'd0);
        vec("and",   OP,     3'b111, 7'h00, 32'h0000FF00, 32'h00FF0000, 32'd0, 32'd0, 32'h0,        1'b0, 32'd0);
        vec("muldiv",OP,     3'b000, 7'h01, 32'd3,        32'd5,        32'd0, 32'd0, 32'h0,        1'b0, 32'd0);

        vec("beq",   BRANCH, 3'b000, 7'h00, 32'd5,        32'd5,        32'd8, 32'h100, 32'h0, 1'b1, 32'h108);
        vec("bne",   BRANCH, 3'b001, 7'h00, 32'd5,        32'd6,        32'd8, 32'h100, 32'h0, 1'b1, 32'h108);
        vec("blt",   BRANCH, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd8, 32'h100, 32'h0, 1'b1, 32'h108);
        vec("bge",   BRANCH, 3'b101, 7'h00, 32'd2,        32'd1,        32'd8, 32'h100, 32'h0, 1'b1, 32'h108);
        vec("bltu",  BRANCH, 3'b110, 7'h00, 32'd1,        32'd2,        32'd8, 32'h100, 32'h0, 1'b1, 32'h108);
        vec("bgeu",  BRANCH, 3'b111, 7'h00, 32'd2,        32'd1,        32'd8, 32'h100, 32'h0, 1'b1, 32'h108);
        vec("blt_nt",BRANCH, 3'b100, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd8, 32'h100, 32'h0, 1'b0, 32'h108);
        vec("br_f3_2",BRANCH,3'b010, 7'h00, 32'd5,        32'd5,        32'd8, 32'h100, 32'h0, 1'b0, 32'h108);

        vec("jal",   JAL,    3'b000, 7'h00, 32'd0,        32'd0,        32'h10, 32'h100, 32'h104, 1'b1, 32'h110);
        vec("jalr",  JALR,   3'b000, 7'h00, 32'h1235,     32'd0,        32'd4,  32'h100, 32'h104, 1'b1, 32'h1238);
        vec("lui",   LUI,    3'b000, 7'h00, 32'd0,        32'd0,        32'h12345000, 32'd0, 32'h12345000, 1'b0, 32'h12345000);
        vec("auipc", AUIPC,  3'b000, 7'h00, 32'd0,        32'd0,        32'h1000, 32'h100, 32'h1100, 1'b0, 32'h1100);
        vec("load",  LOAD,   3'b010, 7'h00, 32'h10,       32'd0,        32'hFFFFFFFC, 32'd0, 32'hC, 1'b0, 32'hFFFFFFFC);

        for (int i = 0; i < 2000; i++) begin
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            r_im = $urandom;
            r_pc = $urandom;
            pick = int'($urandom_range(0, 19));
            r_f7 = (pick < 10) ? 7'h00 : 7'h20;
            if (i >= 1000 && pick == 19) r_f7 = 7'h01;
            if (i >= 1000 && pick == 18) r_f7 = 7'($urandom);
            if (pick == 17) r_b = r_a;
            if (i < 1000)
                vec("rnd_opimm", OP_IMM, r_f3, r_f7, r_a, r_b, r_im, r_pc,
                    model_alu(OP_IMM, r_f3, r_f7, r_a, r_b, r_im), 1'b0, r_pc + r_im);
            else
                vec("rnd_op", OP, r_f3, r_f7, r_a, r_b, r_im, r_pc,
                    model_alu(OP, r_f3, r_f7, r_a, r_b, r_im), 1'b0, r_pc + r_im);
        end

        // Register behaviour: capture, stall hold, reset override while stalled.
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        drive(OP_IMM, 3'b000, 7'h00, 32'd5, 32'd0, 32'd3, 32'h20);
        push_exp("cap", 32'd8, 1'b0, 32'h23);
        @(posedge clk); #1;
        cmp_reg();

        @(negedge clk);
        stall = 1'b1;
        drive(JAL, 3'b000, 7'h00, 32'd1, 32'd1, 32'h40, 32'h200);
        push_exp("stall", 32'd8, 1'b0, 32'h23);
        @(posedge clk); #1;
        cmp_reg();

        @(negedge clk);
        push_exp("stall_comb", 32'h204, 1'b1, 32'h240);
        cmp_comb();
        rst_n = 1'b0;
        #1;
        push_exp("rst_stalled", 32'h0, 1'b0, 32'h0);
        cmp_reg();

        @(posedge clk); #1;
        push_exp("rst_hold", 32'h0, 1'b0, 32'h0);
        cmp_reg();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
